// File: rtl/sprite_dma_pkg.sv
// Shared state encoding and bus constants for the sprite DMA engine.
// The optional ALIGN phase is enabled by defining SPRITE_DMA_ALIGN_EN.
package sprite_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
    ST_ALIGN = 3'd2,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4
  } dma_state_t;

  localparam logic [15:0] OAMDATA_ADDR = 16'h2004;
  localparam int          DMA_LEN      = 256;
  localparam logic [7:0]  LAST_CNT     = 8'(DMA_LEN - 1);

endpackage

// File: rtl/sprite_dma_addr_cnt.sv
// Page/byte-counter registers and DMA bus address mux for sprite_dma.
// Raises o_last while the counter points at the final byte of the page.
module sprite_dma_addr_cnt
  import sprite_dma_pkg::*;
(
  input  logic        CLK,
  input  logic        n_RES,
  input  logic        i_load,
  input  logic [7:0]  i_page,
  input  logic        i_inc,
  input  logic        i_rd_sel,
  input  logic        i_wr_sel,
  output logic [15:0] o_addr,
  output logic        o_last
);

  logic [7:0] r_page;
  logic [7:0] r_cnt;

  always_ff @(posedge CLK) begin
    if (!n_RES) begin
      r_page <= 8'h00;
      r_cnt  <= 8'h00;
    end else if (i_load) begin
      r_page <= i_page;
      r_cnt  <= 8'h00;
    end else if (i_inc) begin
      r_cnt  <= r_cnt + 8'd1;
    end
  end

  assign o_last = (r_cnt == LAST_CNT);

  always_comb begin
    o_addr = 16'h0000;
    if (i_rd_sel)
      o_addr = {r_page, r_cnt};
    else if (i_wr_sel)
      o_addr = OAMDATA_ADDR;
  end

endmodule

// File: rtl/sprite_dma.sv
// OAM sprite DMA: halts the CPU and copies one 256-byte page to $2004.
// Define SPRITE_DMA_ALIGN_EN to insert an ALIGN cycle so READs land on get phases.
module sprite_dma
  import sprite_dma_pkg::*;
(
  input  logic        CLK,
  input  logic        n_RES,
  input  logic        W4014,
  input  logic        RnW_cpu,
  input  logic [7:0]  DB_in,
  output logic        RDY,
  output logic        DMA_ACTIVE,
  output logic [15:0] ADDR,
  output logic        RnW,
  output logic [7:0]  DB_out,
  output logic        DONE
);

`ifdef SPRITE_DMA_ALIGN_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  dma_state_t r_state;
  dma_state_t w_next_state;
  logic       r_phase;
  logic [7:0] r_buf;
  logic       r_done;
  logic       w_load;
  logic       w_inc;
  logic       w_rd_sel;
  logic       w_wr_sel;
  logic       w_last;

  sprite_dma_addr_cnt u_addr_cnt (
    .CLK      (CLK),
    .n_RES    (n_RES),
    .i_load   (w_load),
    .i_page   (DB_in),
    .i_inc    (w_inc),
    .i_rd_sel (w_rd_sel),
    .i_wr_sel (w_wr_sel),
    .o_addr   (ADDR),
    .o_last   (w_last)
  );

  always_ff @(posedge CLK) begin
    if (!n_RES)
      r_state <= ST_IDLE;
    else
      r_state <= w_next_state;
  end

  always_ff @(posedge CLK) begin
    if (!n_RES) begin
      r_phase <= 1'b0;
      r_buf   <= 8'h00;
      r_done  <= 1'b0;
    end else begin
      r_phase <= ~r_phase;
      r_done  <= (r_state == ST_WRITE) && w_last;
      if (r_state == ST_READ)
        r_buf <= DB_in;
    end
  end

  // r_phase==0 now means the following cycle is a put phase, too late for a READ.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (W4014) w_next_state = ST_HALT;
      ST_HALT:  if (RnW_cpu) w_next_state = (ALIGN_EN && !r_phase) ? ST_ALIGN : ST_READ;
      ST_ALIGN: w_next_state = ST_READ;
      ST_READ:  w_next_state = ST_WRITE;
      ST_WRITE: w_next_state = w_last ? ST_IDLE : ST_READ;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    RDY        = 1'b1;
    DMA_ACTIVE = 1'b0;
    RnW        = 1'b1;
    DB_out     = 8'h00;
    w_load     = 1'b0;
    w_inc      = 1'b0;
    w_rd_sel   = 1'b0;
    w_wr_sel   = 1'b0;
    case (r_state)
      ST_IDLE:  w_load = W4014;
      ST_HALT,
      ST_ALIGN: RDY = 1'b0;
      ST_READ: begin
        RDY        = 1'b0;
        DMA_ACTIVE = 1'b1;
        w_rd_sel   = 1'b1;
      end
      ST_WRITE: begin
        RDY        = 1'b0;
        DMA_ACTIVE = 1'b1;
        RnW        = 1'b0;
        DB_out     = r_buf;
        w_wr_sel   = 1'b1;
        w_inc      = 1'b1;
      end
      default: RDY = 1'b1;
    endcase
  end

  assign DONE = r_done;

endmodule

// File: tb/tb_sprite_dma.sv
// Self-checking bench for sprite_dma against a cycle-count/bus-transaction model.
// Honours SPRITE_DMA_ALIGN_EN the same way the design does.
module tb_sprite_dma;

  logic        CLK     = 1'b0;
  logic        n_RES   = 1'b0;
  logic        W4014   = 1'b0;
  logic        RnW_cpu = 1'b1;
  logic [7:0]  DB_in   = 8'h00;
  logic        RDY, DMA_ACTIVE, RnW, DONE;
  logic [15:0] ADDR;
  logic [7:0]  DB_out;

  int errors = 0;
  int checks = 0;

`ifdef SPRITE_DMA_ALIGN_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  sprite_dma dut (
    .CLK        (CLK),
    .n_RES      (n_RES),
    .W4014      (W4014),
    .RnW_cpu    (RnW_cpu),
    .DB_in      (DB_in),
    .RDY        (RDY),
    .DMA_ACTIVE (DMA_ACTIVE),
    .ADDR       (ADDR),
    .RnW        (RnW),
    .DB_out     (DB_out),
    .DONE       (DONE)
  );

  always #5 CLK = ~CLK;

  // Expected get/put phase of the current cycle.
  logic tb_phase = 1'b0;
  always @(posedge CLK) tb_phase <= n_RES ? ~tb_phase : 1'b0;

  logic [7:0]  mem_key = 8'h00;
  logic [15:0] obs_addr [0:1023];
  logic        obs_rnw  [0:1023];
  logic [7:0]  obs_data [0:1023];
  int          obs_n, rdy_low, last_low, first_act, done_cnt, done_cyc;
  logic        done_rdy, done_act, issue_phase, idle_rnw_and;
  logic [15:0] idle_addr_or;
  logic [7:0]  idle_db_or;

  function automatic logic [7:0] mem_read(input logic [15:0] a);
    return a[7:0] ^ mem_key;
  endfunction

  function automatic logic [15:0] exp_addr(input logic [7:0] pg, input int i);
    return (i % 2 == 0) ? {pg, 8'(i / 2)} : 16'h2004;
  endfunction

  function automatic logic exp_rnw(input int i);
    return (i % 2 == 0);
  endfunction

  function automatic logic [7:0] exp_data(input int i);
    return 8'(i / 2) ^ mem_key;
  endfunction

  // Cycle index (W4014 cycle = 0) of the first READ; with alignment it must be a get phase.
  function automatic int exp_first_read(input int stalls, input logic p0);
    int f;
    f = stalls + 2;
    if (ALIGN_EN && ((p0 ^ f[0]) != 1'b0)) f++;
    return f;
  endfunction

  task automatic run_dma(input logic [7:0] page, input int want_phase, input int stalls,
                         input int inject_at, input int abort_at);
    obs_n = 0; rdy_low = 0; last_low = 0; first_act = 0; done_cnt = 0; done_cyc = 0;
    done_rdy = 1'b0; done_act = 1'b1;
    idle_addr_or = 16'h0000; idle_db_or = 8'h00; idle_rnw_and = 1'b1;
    @(negedge CLK);
    if (want_phase >= 0)
      while (tb_phase !== want_phase[0]) @(negedge CLK);
    issue_phase = tb_phase;
    W4014 = 1'b1; DB_in = page; RnW_cpu = 1'b1;
    for (int cyc = 1; cyc <= 900; cyc++) begin
      @(negedge CLK);
      W4014   = 1'b0;
      RnW_cpu = (cyc > stalls);
      DB_in   = 8'($urandom);
      if (!RDY) begin rdy_low++; last_low = cyc; end
      if (DMA_ACTIVE) begin
        if (first_act == 0) first_act = cyc;
        obs_addr[obs_n] = ADDR; obs_rnw[obs_n] = RnW; obs_data[obs_n] = DB_out;
        if (obs_n < 1023) obs_n++;
        if (RnW) DB_in = mem_read(ADDR);
        else if (obs_n - 1 == inject_at) begin W4014 = 1'b1; DB_in = 8'h07; end
        if (abort_at >= 0 && RnW && ADDR[7:0] == 8'(abort_at)) begin
          n_RES = 1'b0;
          break;
        end
      end else begin
        idle_addr_or |= ADDR; idle_db_or |= DB_out; idle_rnw_and &= RnW;
      end
      if (DONE) begin
        done_cnt++;
        if (done_cnt == 1) begin done_cyc = cyc; done_rdy = RDY; done_act = DMA_ACTIVE; end
      end
      if (done_cnt > 0 && cyc >= done_cyc + 2) break;
    end
    W4014 = 1'b0; RnW_cpu = 1'b1;
  endtask

  task automatic test_reset;
    n_RES = 1'b0; W4014 = 1'b1; DB_in = 8'hFF;
    repeat (3) @(negedge CLK);
    checks++; if (RDY !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b want 1", RDY); end
    checks++; if (DMA_ACTIVE !== 1'b0) begin errors++; $display("FAIL reset_active: got %b want 0", DMA_ACTIVE); end
    checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", DONE); end
    checks++; if (ADDR !== 16'h0000) begin errors++; $display("FAIL reset_addr: got %h want 0000", ADDR); end
    checks++; if (RnW !== 1'b1) begin errors++; $display("FAIL reset_rnw: got %b want 1", RnW); end
    checks++; if (DB_out !== 8'h00) begin errors++; $display("FAIL reset_dbout: got %h want 00", DB_out); end
    W4014 = 1'b0; n_RES = 1'b1;
    repeat (2) @(negedge CLK);
    checks++; if (RDY !== 1'b1) begin errors++; $display("FAIL reset_no_start: RDY got %b want 1", RDY); end
    $display("test_reset: done");
  endtask

  task automatic test_aligned;
    int ef, bad;
    mem_key = 8'($urandom);
    run_dma(8'h02, 0, 0, -1, -1);
    ef = exp_first_read(0, issue_phase);
    checks++; if (first_act != ef) begin errors++; $display("FAIL aligned_first: got %0d want %0d", first_act, ef); end
    checks++; if (rdy_low != 513) begin errors++; $display("FAIL aligned_rdy_low: got %0d want 513", rdy_low); end
    checks++; if (last_low != rdy_low) begin errors++; $display("FAIL aligned_rdy_contig: last low %0d want %0d", last_low, rdy_low); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL aligned_done_cnt: got %0d want 1", done_cnt); end
    checks++; if (done_cyc != ef + 512) begin errors++; $display("FAIL aligned_done_cyc: got %0d want %0d", done_cyc, ef + 512); end
    checks++; if (done_rdy !== 1'b1 || done_act !== 1'b0) begin errors++; $display("FAIL aligned_done_outs: rdy=%b act=%b want rdy=1 act=0", done_rdy, done_act); end
    checks++; if (idle_addr_or !== 16'h0 || idle_db_or !== 8'h0 || idle_rnw_and !== 1'b1) begin errors++;
      $display("FAIL aligned_idle_bus: addr_or=%h db_or=%h rnw_and=%b want 0000 00 1", idle_addr_or, idle_db_or, idle_rnw_and); end
    bad = 0;
    for (int i = 0; i < obs_n; i++)
      if (obs_addr[i] !== exp_addr(8'h02, i) || obs_rnw[i] !== exp_rnw(i) || (i % 2 == 1 && obs_data[i] !== exp_data(i))) bad++;
    checks++; if (bad != 0 || obs_n != 512) begin errors++; $display("FAIL aligned_seq: mismatches=%0d count=%0d want 0 and 512", bad, obs_n); end
    $display("test_aligned: first=%0d rdy_low=%0d transactions=%0d", first_act, rdy_low, obs_n);
  endtask

  task automatic test_align_phase;
    int ef, bad, want_low;
    mem_key = 8'($urandom);
    run_dma(8'h02, 1, 0, -1, -1);
    ef = exp_first_read(0, issue_phase);
    want_low = ALIGN_EN ? 514 : 513;
    checks++; if (rdy_low != want_low) begin errors++; $display("FAIL align_rdy_low: got %0d want %0d", rdy_low, want_low); end
    checks++; if (first_act != ef) begin errors++; $display("FAIL align_first: got %0d want %0d", first_act, ef); end
    bad = 0;
    for (int i = 0; i < obs_n; i++)
      if (obs_addr[i] !== exp_addr(8'h02, i) || obs_rnw[i] !== exp_rnw(i) || (i % 2 == 1 && obs_data[i] !== exp_data(i))) bad++;
    checks++; if (bad != 0 || obs_n != 512) begin errors++; $display("FAIL align_seq: mismatches=%0d count=%0d want 0 and 512", bad, obs_n); end
    $display("test_align_phase: first=%0d rdy_low=%0d", first_act, rdy_low);
  endtask

  task automatic test_stall;
    int ef;
    mem_key = 8'($urandom);
    run_dma(8'h02, 0, 2, -1, -1);
    ef = exp_first_read(2, issue_phase);
    checks++; if (first_act != ef) begin errors++; $display("FAIL stall_first: got %0d want %0d", first_act, ef); end
    checks++; if (rdy_low != ef - 1 + 512) begin errors++; $display("FAIL stall_rdy_low: got %0d want %0d", rdy_low, ef - 1 + 512); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL stall_done_cnt: got %0d want 1", done_cnt); end
    $display("test_stall: first=%0d rdy_low=%0d", first_act, rdy_low);
  endtask

  task automatic test_pattern;
    int bad, writes;
    mem_key = 8'h5A;
    run_dma(8'h02, -1, 0, -1, -1);
    bad = 0; writes = 0;
    for (int i = 0; i < obs_n; i++) begin
      if (!obs_rnw[i]) writes++;
      if (obs_addr[i] !== exp_addr(8'h02, i) || obs_rnw[i] !== exp_rnw(i) || (i % 2 == 1 && obs_data[i] !== exp_data(i))) bad++;
    end
    checks++; if (writes != 256) begin errors++; $display("FAIL pattern_writes: got %0d want 256", writes); end
    checks++; if (obs_data[1] !== 8'h5A) begin errors++; $display("FAIL pattern_first: got %h want 5a", obs_data[1]); end
    checks++; if (obs_data[511] !== 8'hA5) begin errors++; $display("FAIL pattern_last: got %h want a5", obs_data[511]); end
    checks++; if (bad != 0) begin errors++; $display("FAIL pattern_seq: mismatches=%0d want 0", bad); end
    $display("test_pattern: writes=%0d", writes);
  endtask

  task automatic test_ignore_w4014;
    int bad;
    mem_key = 8'($urandom);
    run_dma(8'h02, -1, 0, 201, -1);
    bad = 0;
    for (int i = 0; i < obs_n; i++)
      if (obs_addr[i] !== exp_addr(8'h02, i) || obs_rnw[i] !== exp_rnw(i) || (i % 2 == 1 && obs_data[i] !== exp_data(i))) bad++;
    checks++; if (bad != 0 || obs_n != 512) begin errors++; $display("FAIL ignore_seq: mismatches=%0d count=%0d want 0 and 512", bad, obs_n); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL ignore_done_cnt: got %0d want 1", done_cnt); end
    $display("test_ignore_w4014: transactions=%0d", obs_n);
  endtask

  task automatic test_reset_mid;
    int bad, busy;
    mem_key = 8'($urandom);
    run_dma(8'h02, -1, 0, -1, 100);
    @(negedge CLK);
    checks++; if (RDY !== 1'b1 || DMA_ACTIVE !== 1'b0 || DONE !== 1'b0) begin errors++;
      $display("FAIL midrst_ctrl: rdy=%b act=%b done=%b want 1 0 0", RDY, DMA_ACTIVE, DONE); end
    checks++; if (ADDR !== 16'h0 || RnW !== 1'b1 || DB_out !== 8'h0) begin errors++;
      $display("FAIL midrst_bus: addr=%h rnw=%b db=%h want 0000 1 00", ADDR, RnW, DB_out); end
    checks++; if (obs_n != 201) begin errors++; $display("FAIL midrst_count: got %0d want 201", obs_n); end
    n_RES = 1'b1;
    busy = 0;
    repeat (20) begin
      @(negedge CLK);
      if (DMA_ACTIVE !== 1'b0 || RDY !== 1'b1) busy++;
    end
    checks++; if (busy != 0) begin errors++; $display("FAIL midrst_quiet: busy cycles=%0d want 0", busy); end
    run_dma(8'h33, -1, 0, -1, -1);
    bad = 0;
    for (int i = 0; i < obs_n; i++)
      if (obs_addr[i] !== exp_addr(8'h33, i) || obs_rnw[i] !== exp_rnw(i) || (i % 2 == 1 && obs_data[i] !== exp_data(i))) bad++;
    checks++; if (bad != 0 || obs_n != 512) begin errors++; $display("FAIL midrst_restart: mismatches=%0d count=%0d want 0 and 512", bad, obs_n); end
    $display("test_reset_mid: restart transactions=%0d", obs_n);
  endtask

  task automatic test_back_to_back;
    int ef, bad, st;
    logic [7:0] pg;
    for (int n = 0; n < 4; n++) begin
      pg = 8'($urandom);
      mem_key = 8'($urandom);
      st = int'($urandom_range(0, 3));
      run_dma(pg, -1, st, -1, -1);
      ef = exp_first_read(st, issue_phase);
      checks++; if (first_act != ef) begin errors++; $display("FAIL b2b_first[%0d]: got %0d want %0d", n, first_act, ef); end
      checks++; if (rdy_low != ef - 1 + 512) begin errors++; $display("FAIL b2b_rdy_low[%0d]: got %0d want %0d", n, rdy_low, ef - 1 + 512); end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL b2b_done[%0d]: got %0d want 1", n, done_cnt); end
      bad = 0;
      for (int i = 0; i < obs_n; i++)
        if (obs_addr[i] !== exp_addr(pg, i) || obs_rnw[i] !== exp_rnw(i) || (i % 2 == 1 && obs_data[i] !== exp_data(i))) bad++;
      checks++; if (bad != 0 || obs_n != 512) begin errors++; $display("FAIL b2b_seq[%0d]: mismatches=%0d count=%0d want 0 and 512", n, bad, obs_n); end
      $display("test_back_to_back[%0d]: page=%h stalls=%0d first=%0d rdy_low=%0d", n, pg, st, first_act, rdy_low);
    end
  endtask

  initial begin
    test_reset;
    test_aligned;
    test_align_phase;
    test_stall;
    test_pattern;
    test_ignore_w4014;
    test_reset_mid;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
